// File: rtl/riscky_pkg.sv
// Shared core-wide types and sizes for the riscky pipeline.
// Fetch-related additions: FSM state enum, PC increment and IF/ID record.
package riscky_pkg;

    localparam int XLEN       = 32;
    localparam int ILEN       = 32;
    localparam int IMEM_AW    = 8;
    localparam int IMEM_WORDS = 1 << IMEM_AW;

    localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register holding one if_id_t record with flush/load/hold control.
// Flush wins over load and only clears the valid bit; payload is left as is.
module if_id_reg
    import riscky_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush_i,
    input  logic   load_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t q_q;
    if_id_t q_d;

    always_comb begin
        q_d = q_q;
        if (flush_i) begin
            q_d.valid = 1'b0;
        end else if (load_i) begin
            q_d       = d_i;
            q_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IDLE/RUN control, redirect handling and IF/ID register.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
    import riscky_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [ILEN-1:0]    imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [ILEN-1:0]    id_instr,
    output logic [XLEN-1:0]    id_pc,
    output logic               misalign_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic            load;
    logic            capture;
    logic            flush;
    if_id_t          if_id_d;
    if_id_t          if_id_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fetch_en) state_d = RUN;
            RUN:     if (!fetch_en && !redirect_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A redirect flushes the in-flight fetch even when decode is stalled.
    always_comb begin
        load       = !if_id_q.valid || id_ready;
        capture    = (state_q == RUN) && load && !redirect_valid;
        flush      = redirect_valid || ((state_q == IDLE) && id_ready);
        misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);
        pc_d       = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (capture) begin
            pc_d = pc_q + PC_INC;
        end
        if_id_d       = '0;
        if_id_d.pc    = pc_q;
        if_id_d.instr = imem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .load_i  (capture),
        .d_i     (if_id_d),
        .q_o     (if_id_q)
    );

    assign imem_addr    = pc_q[IMEM_AW+1:2];
    assign id_valid     = if_id_q.valid;
    assign id_instr     = if_id_q.instr;
    assign id_pc        = if_id_q.pc;
    assign misalign_err = misalign_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (capture) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if ((state_q == RUN) && if_id_q.valid && !id_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand-written reset sequences.
// Counter checks are compiled in only when FETCH_PERF_EN is defined.
module tb_fetch_unit;

    logic        clk;
    logic        rstN;
    logic        fetchEn;
    logic [7:0]  imemAddr;
    logic [31:0] imemRdata;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        idValid;
    logic        idReady;
    logic [31:0] idInstr;
    logic [31:0] idPc;
    logic        misalignErr;
`ifdef FETCH_PERF_EN
    logic [31:0] perfFetchCnt;
    logic [31:0] perfStallCnt;
`endif

    logic [31:0] mem [256];
    int          compared;
    int          mismatched;

    localparam logic [31:0] W0 = 32'h0020_82B3;
    localparam logic [31:0] W1 = 32'h0051_82B3;
    localparam logic [31:0] W2 = 32'h0052_02B3;

    typedef struct {
        logic        fe;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expInstr;
        logic [7:0]  expAddr;
        logic        expMis;
        logic        chkData;
    } vec_t;

    vec_t vecs[$];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rstN),
        .fetch_en       (fetchEn),
        .imem_addr      (imemAddr),
        .imem_rdata     (imemRdata),
        .redirect_valid (redirectValid),
        .redirect_pc    (redirectPc),
        .id_valid       (idValid),
        .id_ready       (idReady),
        .id_instr       (idInstr),
        .id_pc          (idPc),
        .misalign_err   (misalignErr)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perfFetchCnt),
        .perf_stall_cnt (perfStallCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imemRdata = mem[imemAddr];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc,
                                input logic v, input logic [31:0] pc, input logic [31:0] instr,
                                input logic [7:0] addr, input logic mis, input logic chk);
        vec_t r;
        r.fe = fe; r.rdy = rdy; r.rv = rv; r.rpc = rpc;
        r.expValid = v; r.expPc = pc; r.expInstr = instr;
        r.expAddr = addr; r.expMis = mis; r.chkData = chk;
        return r;
    endfunction

    task automatic applyStimulus(input vec_t v);
        fetchEn       = v.fe;
        idReady       = v.rdy;
        redirectValid = v.rv;
        redirectPc    = v.rpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        cmp({tag, " id_valid"}, 32'(idValid), 32'(v.expValid));
        cmp({tag, " imem_addr"}, 32'(imemAddr), 32'(v.expAddr));
        cmp({tag, " misalign_err"}, 32'(misalignErr), 32'(v.expMis));
        if (v.chkData) begin
            cmp({tag, " id_pc"}, idPc, v.expPc);
            cmp({tag, " id_instr"}, idInstr, v.expInstr);
        end
    endtask

    task automatic checkReset(input string tag);
        cmp({tag, " id_valid"}, 32'(idValid), 32'd0);
        cmp({tag, " id_pc"}, idPc, 32'd0);
        cmp({tag, " id_instr"}, idInstr, 32'd0);
        cmp({tag, " imem_addr"}, 32'(imemAddr), 32'd0);
        cmp({tag, " misalign_err"}, 32'(misalignErr), 32'd0);
`ifdef FETCH_PERF_EN
        cmp({tag, " perf_fetch_cnt"}, perfFetchCnt, 32'd0);
        cmp({tag, " perf_stall_cnt"}, perfStallCnt, 32'd0);
`endif
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = W0;
        mem[1] = W1;
        mem[2] = W2;

        // Startup, three-cycle stall at id_pc=4, redirect, misaligned redirect, alias, wrap, IDLE drain.
        vecs.push_back(mk(1,1,0,32'h0,        0,32'h0,        32'h0,        8'd0,   0,1));
        vecs.push_back(mk(1,1,0,32'h0,        1,32'h0,        W0,           8'd1,   0,1));
        vecs.push_back(mk(1,1,0,32'h0,        1,32'h4,        W1,           8'd2,   0,1));
        vecs.push_back(mk(1,0,0,32'h0,        1,32'h4,        W1,           8'd2,   0,1));
        vecs.push_back(mk(1,0,0,32'h0,        1,32'h4,        W1,           8'd2,   0,1));
        vecs.push_back(mk(1,0,0,32'h0,        1,32'h4,        W1,           8'd2,   0,1));
        vecs.push_back(mk(1,1,0,32'h0,        1,32'h8,        W2,           8'd3,   0,1));
        vecs.push_back(mk(1,0,1,32'h20,       0,32'h0,        32'h0,        8'd8,   0,0));
        vecs.push_back(mk(1,1,0,32'h0,        1,32'h20,       32'hA000_0008,8'd9,   0,1));
        vecs.push_back(mk(1,1,1,32'h22,       0,32'h0,        32'h0,        8'd8,   1,0));
        vecs.push_back(mk(1,1,0,32'h0,        1,32'h20,       32'hA000_0008,8'd9,   0,1));
        vecs.push_back(mk(1,1,0,32'h0,        1,32'h24,       32'hA000_0009,8'd10,  0,1));
        vecs.push_back(mk(1,1,1,32'h400,      0,32'h0,        32'h0,        8'd0,   0,0));
        vecs.push_back(mk(1,1,0,32'h0,        1,32'h400,      W0,           8'd1,   0,1));
        vecs.push_back(mk(1,1,1,32'hFFFF_FFFC,0,32'h0,        32'h0,        8'd255, 0,0));
        vecs.push_back(mk(1,1,0,32'h0,        1,32'hFFFF_FFFC,32'hA000_00FF,8'd0,   0,1));
        vecs.push_back(mk(1,1,0,32'h0,        1,32'h0,        W0,           8'd1,   0,1));
        vecs.push_back(mk(0,0,0,32'h0,        1,32'h0,        W0,           8'd1,   0,1));
        vecs.push_back(mk(0,0,0,32'h0,        1,32'h0,        W0,           8'd1,   0,1));
        vecs.push_back(mk(0,1,0,32'h0,        0,32'h0,        32'h0,        8'd1,   0,0));
        vecs.push_back(mk(0,1,0,32'h0,        0,32'h0,        32'h0,        8'd1,   0,0));
        vecs.push_back(mk(1,1,0,32'h0,        0,32'h0,        32'h0,        8'd1,   0,0));
        vecs.push_back(mk(1,1,0,32'h0,        1,32'h4,        W1,           8'd2,   0,1));

        rstN          = 1'b0;
        fetchEn       = 1'b0;
        idReady       = 1'b1;
        redirectValid = 1'b0;
        redirectPc    = '0;
        repeat (3) tick();
        checkReset("reset");
        rstN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset while streaming must return everything to reset values at the next edge.
        rstN = 1'b0;
        tick();
        checkReset("midreset");
        rstN = 1'b1;

        // Fresh run: 10 fetches with a 3-cycle stall in the middle.
        fetchEn = 1'b1;
        idReady = 1'b1;
        tick();
        repeat (5) tick();
        idReady = 1'b0;
        repeat (3) tick();
        cmp("stall hold id_pc", idPc, 32'h10);
        idReady = 1'b1;
        repeat (5) tick();
        cmp("run id_valid", 32'(idValid), 32'd1);
        cmp("run id_pc", idPc, 32'h24);
        cmp("run id_instr", idInstr, 32'hA000_0009);
`ifdef FETCH_PERF_EN
        cmp("perf_fetch_cnt", perfFetchCnt, 32'd10);
        cmp("perf_stall_cnt", perfStallCnt, 32'd3);
`endif
        rstN = 1'b0;
        tick();
        checkReset("perfreset");
        rstN = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
